fp_mul_issuer: RTL and testbench
================================

Name: fp_mul_issuer

Overview:
- Initiator end of the fp multiplier strobe/ack protocol.
- Accepts operand pairs from upstream on a valid/ready port and buffers them in a small FIFO.
- Issues each pair to the multiplier as A, then B, collects the product, and presents it downstream with a sequence tag.
- Used by test harnesses and by the FPU dispatch path as the single driver of one multiplier instance.

Parameters:
- DEPTH, 4, operand-pair FIFO entries (power of 2, ≥2)
- TAG_W, 4, width of sequence tag
- TIMEOUT, 256, max cycles in WAIT_P before timeout_err is set (0 disables)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous reset, active-high
- op_a  in  32  operand A (IEEE-754 single)
- op_b  in  32  operand B
- op_valid  in  1  upstream operand pair valid
- op_ready  out  1  FIFO not full
- mul_a  out  32  A data to multiplier
- mul_a_stb  out  1  A strobe
- mul_a_ack  in  1  multiplier ready for A
- mul_b  out  32  B data to multiplier
- mul_b_stb  out  1  B strobe
- mul_b_ack  in  1  multiplier ready for B
- mul_z  in  32  product from multiplier
- mul_z_stb  in  1  product strobe
- mul_z_ack  out  1  product acknowledge
- res_z  out  32  product to downstream
- res_tag  out  TAG_W  tag of the pair that produced res_z
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts
- busy  out  1  FIFO non-empty or state ≠ IDLE
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (reset=1 at edge): state=IDLE, FIFO empty, tag counter=0, watchdog=0.
- Reset output values: all stb/ack/valid=0, res_z=0, res_tag=0, timeout_err=0, busy=0, op_ready=1.
- Reset overrides any in-flight operation. The multiplier must be reset in the same cycle (system rule).
- Transfer rule, all three channels: a transfer occurs on an edge where strobe and ack are both 1.
- Data and strobe are held stable from assertion until transfer.
- Strobe drops the cycle after transfer.
- Push: on op_valid & op_ready, {op_a, op_b, tag} is written and tag increments, wrapping 2^TAG_W−1 → 0.
- op_ready = !full, derived from the registered count. No push is accepted when full, even if a pop occurs in the same cycle.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into holding regs (mul_a, mul_b, cur_tag), set mul_a_stb=1, go SEND_A. Capacity is DEPTH queued plus 1 in flight.
  - SEND_A: on mul_a_stb & mul_a_ack, clear mul_a_stb, set mul_b_stb=1, go SEND_B.
  - SEND_B: on mul_b_stb & mul_b_ack, clear mul_b_stb, set mul_z_ack=1, clear watchdog, go WAIT_P.
  - WAIT_P: on mul_z_stb & mul_z_ack, capture res_z=mul_z and res_tag=cur_tag, clear mul_z_ack, set res_valid=1, go OUT.
  - WAIT_P watchdog: increments each cycle; on reaching TIMEOUT, set timeout_err (sticky until reset). Waiting continues; there is no abort.
  - OUT: on res_valid & res_ready, clear res_valid, go IDLE.
- res_z and res_tag hold while res_valid=1.
- No new issue occurs while in OUT, so there is exactly one pair in flight.
- Latency:
  - Push at edge t gives mul_a_stb=1 after edge t+1 when the FIFO was empty and the FSM was IDLE.
  - Product transfer at edge t gives res_valid=1 after edge t.
- Push and issue pop may occur in the same cycle. Count is unchanged and data stays correct, including for DEPTH=2 and when the pointers wrap.
- The block never reorders results. Tags emerge in push order.

Test Plan:
- Basic: push op_a=0x40000000, op_b=0x40400000 against the behavioural multiplier model -> res_z=0x40C00000, res_tag=0, one A, one B and one Z transfer each.
- Full: DEPTH=4, mul_a_ack held 0, 6 pushes offered -> 5 accepted (1 held + 4 queued), op_ready=0 until ack released. All 5 results then arrive in order with tags 0..4.
- Backpressure: res_ready=0 for 10 cycles with more ops queued -> res_valid, res_z and res_tag stable, mul_a_stb stays 0. Next issue starts 1 cycle after the res_ready transfer.
- Watchdog: TIMEOUT=16, mul_z_stb withheld 40 cycles -> timeout_err=1 from the 16th WAIT_P cycle. Late product is still delivered correctly and timeout_err remains 1.
- Reset mid-op: assert reset during SEND_B with 3 queued -> next cycle all strobes/acks/valids=0, op_ready=1, busy=0. Next push gets tag 0.
- Tag wrap: 17 sequential ops -> tags 0..15 then 0, with products matching 17 random normal pairs from the reference model.

Source files
------------

// File: rtl/fp_mul_issuer.sv
// Initiator side of the fp multiplier strobe/ack protocol: queues operand pairs,
// issues them one at a time as A then B, and returns each product with its sequence tag.
module fp_mul_issuer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  input  logic             op_valid,
  output logic             op_ready,
  output logic [31:0]      mul_a,
  output logic             mul_a_stb,
  input  logic             mul_a_ack,
  output logic [31:0]      mul_b,
  output logic             mul_b_stb,
  input  logic             mul_b_ack,
  input  logic [31:0]      mul_z,
  input  logic             mul_z_stb,
  output logic             mul_z_ack,
  output logic [31:0]      res_z,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             timeout_err
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    WAIT_P,
    OUT
  } state_t;

  state_t state, state_nxt;

  logic [31:0]      fifo_a   [DEPTH];
  logic [31:0]      fifo_b   [DEPTH];
  logic [TAG_W-1:0] fifo_tag [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [TAG_W-1:0] tag_cnt, cur_tag;
  logic [WD_W-1:0]  wd_cnt;
  logic             full, empty, push, pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = op_valid && !full;
  assign pop   = (state == IDLE) && !empty;

  assign op_ready  = !full;
  assign busy      = !empty || (state != IDLE);

  // Each strobe/ack/valid is high for exactly the state that owns that channel.
  assign mul_a_stb = (state == SEND_A);
  assign mul_b_stb = (state == SEND_B);
  assign mul_z_ack = (state == WAIT_P);
  assign res_valid = (state == OUT);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!empty)    state_nxt = SEND_A;
      SEND_A:  if (mul_a_ack) state_nxt = SEND_B;
      SEND_B:  if (mul_b_ack) state_nxt = WAIT_P;
      WAIT_P:  if (mul_z_stb) state_nxt = OUT;
      OUT:     if (res_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr]   <= op_a;
      fifo_b[wr_ptr]   <= op_b;
      fifo_tag[wr_ptr] <= tag_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tag_cnt     <= '0;
      cur_tag     <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      res_z       <= '0;
      res_tag     <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;

      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        tag_cnt <= tag_cnt + 1'b1;
      end

      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        mul_a   <= fifo_a[rd_ptr];
        mul_b   <= fifo_b[rd_ptr];
        cur_tag <= fifo_tag[rd_ptr];
      end

      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;

      // Holding the counter at zero throughout SEND_B clears it on the B transfer.
      if (state == SEND_B) begin
        wd_cnt <= '0;
      end else if (state == WAIT_P) begin
        if (wd_cnt != WD_LAST) wd_cnt <= wd_cnt + 1'b1;
        if ((TIMEOUT != 0) && (wd_cnt == WD_LAST)) timeout_err <= 1'b1;
      end

      if ((state == WAIT_P) && mul_z_stb) begin
        res_z   <= mul_z;
        res_tag <= cur_tag;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_issuer.sv
// Directed-random bench for fp_mul_issuer: a behavioural multiplier answers the
// strobe/ack channels and a push-ordered scoreboard predicts every result and tag.
module tb_fp_mul_issuer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic             clk;
  logic             reset;
  logic [31:0]      op_a, op_b;
  logic             op_valid, op_ready;
  logic [31:0]      mul_a, mul_b, mul_z;
  logic             mul_a_stb, mul_a_ack, mul_b_stb, mul_b_ack;
  logic             mul_z_stb, mul_z_ack;
  logic [31:0]      res_z;
  logic [TAG_W-1:0] res_tag;
  logic             res_valid, res_ready;
  logic             busy, timeout_err;

  fp_mul_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .mul_a(mul_a), .mul_a_stb(mul_a_stb), .mul_a_ack(mul_a_ack),
    .mul_b(mul_b), .mul_b_stb(mul_b_stb), .mul_b_ack(mul_b_ack),
    .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
    .res_z(res_z), .res_tag(res_tag), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, expv);
    end
  endtask

  // Reference single-precision multiply for normal operands with normal results.
  function automatic logic [63:0] to_double(input logic [31:0] f);
    return {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    real         p;
    logic [63:0] d;
    logic [31:0] r;
    p = $bitstoreal(to_double(a)) * $bitstoreal(to_double(b));
    d = $realtobits(p);
    r = {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    if (d[28] && ((d[27:0] != '0) || d[29])) r = r + 32'd1;
    return r;
  endfunction

  function automatic logic [31:0] rand_normal();
    logic [7:0] e;
    e = 8'($urandom_range(144, 110));
    return {1'($urandom_range(1, 0)), e, 23'($urandom)};
  endfunction

  // Behavioural multiplier and scoreboard, acting half a cycle away from the DUT edge.
  typedef struct {
    logic [31:0]      z;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             head;
  logic [TAG_W-1:0] tag_model;
  bit               a_ack_en, b_ack_en;
  int               z_delay, zw, stage;
  int               na, nb, nz, delivered;
  logic [31:0]      last_z, last_tag;
  bit               xp, xa, xb, xz, xr;
  logic [31:0]      pa, pb, ca, cb, ma, mb;

  initial begin
    stage = 0; zw = 0; na = 0; nb = 0; nz = 0; delivered = 0;
    xp = 0; xa = 0; xb = 0; xz = 0; xr = 0; tag_model = '0;
    mul_a_ack = 0; mul_b_ack = 0; mul_z_stb = 0; mul_z = '0;
    last_z = '0; last_tag = '0;
  end

  always @(negedge clk) begin
    if (reset) begin
      stage = 0; zw = 0;
      xp = 0; xa = 0; xb = 0; xz = 0; xr = 0;
      exp_q.delete();
      tag_model = '0;
      mul_a_ack = 0; mul_b_ack = 0; mul_z_stb = 0; mul_z = '0;
    end else begin
      if (xp) begin
        exp_q.push_back('{z: fmul(pa, pb), tag: tag_model});
        tag_model = tag_model + 1'b1;
      end
      if (xa) begin ma = ca; stage = 1; na++; end
      if (xb) begin mb = cb; stage = 2; zw = z_delay; nb++; end
      if (xz) begin
        stage = 0; nz++;
        chk("res_valid_after_product", 32'(res_valid), 32'd1);
      end
      if (xr) begin
        vectors++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_result: observed z=%h tag=%0d expected none", res_z, res_tag);
        end
        if (exp_q.size() != 0) begin
          head = exp_q.pop_front();
          chk("res_z", res_z, head.z);
          chk("res_tag", 32'(res_tag), 32'(head.tag));
        end
        last_z = res_z; last_tag = 32'(res_tag);
        delivered++;
      end
      if (stage == 2 && zw > 0) zw--;
      mul_a_ack = a_ack_en && (stage == 0);
      mul_b_ack = b_ack_en && (stage == 1);
      mul_z_stb = (stage == 2) && (zw == 0);
      mul_z     = mul_z_stb ? fmul(ma, mb) : '0;
      xp = op_valid && op_ready;   pa = op_a;  pb = op_b;
      xa = mul_a_stb && mul_a_ack; ca = mul_a;
      xb = mul_b_stb && mul_b_ack; cb = mul_b;
      xz = mul_z_stb && mul_z_ack;
      xr = res_valid && res_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pairs(input int n, input string name);
    int sent = 0;
    int g    = 0;
    bit acc;
    op_a = rand_normal(); op_b = rand_normal(); op_valid = 1;
    while (sent < n && g < 2000) begin
      acc = op_ready;
      tick();
      g++;
      if (acc) begin
        sent++;
        op_a = rand_normal(); op_b = rand_normal();
      end
    end
    op_valid = 0;
    chk(name, sent, n);
  endtask

  task automatic wait_delivered(input int n, input string name);
    int g = 0;
    while (delivered < n && g < 1000) begin tick(); g++; end
    chk(name, delivered, n);
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while (busy && g < 1000) begin tick(); g++; end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1; tick(); tick(); reset = 0;
  endtask

  initial begin
    int acc_cnt, base, g;
    bit acc;
    reset = 1; op_valid = 0; op_a = '0; op_b = '0; res_ready = 1;
    a_ack_en = 1; b_ack_en = 1; z_delay = 0;
    tick(); tick();

    chk("rst_mul_a_stb", 32'(mul_a_stb), 0);
    chk("rst_mul_b_stb", 32'(mul_b_stb), 0);
    chk("rst_mul_z_ack", 32'(mul_z_ack), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_z", res_z, 0);
    chk("rst_res_tag", 32'(res_tag), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_op_ready", 32'(op_ready), 1);
    reset = 0;

    // Basic: 2.0 * 3.0 with issue latency checks.
    op_a = 32'h4000_0000; op_b = 32'h4040_0000; op_valid = 1;
    tick();
    op_valid = 0;
    chk("lat_push_edge_a_stb", 32'(mul_a_stb), 0);
    tick();
    chk("lat_push_plus1_a_stb", 32'(mul_a_stb), 1);
    wait_delivered(1, "basic_delivered");
    chk("basic_res_z", last_z, 32'h40C0_0000);
    chk("basic_res_tag", last_tag, 0);
    chk("basic_a_xfers", na, 1);
    chk("basic_b_xfers", nb, 1);
    chk("basic_z_xfers", nz, 1);
    wait_idle("basic_idle");

    // Full: A channel stalled, six offers, five accepted.
    do_reset();
    a_ack_en = 0;
    acc_cnt = 0;
    op_a = rand_normal(); op_b = rand_normal(); op_valid = 1;
    for (int i = 0; i < 8; i++) begin
      acc = op_ready;
      tick();
      if (acc) begin
        acc_cnt++;
        op_a = rand_normal(); op_b = rand_normal();
      end
    end
    chk("full_accepted", acc_cnt, 5);
    chk("full_op_ready", 32'(op_ready), 0);
    chk("full_a_stb_held", 32'(mul_a_stb), 1);
    op_valid = 0;
    base = delivered;
    a_ack_en = 1;
    wait_delivered(base + 5, "full_delivered");
    chk("full_last_tag", last_tag, 4);
    chk("full_op_ready_after", 32'(op_ready), 1);
    wait_idle("full_idle");

    // Backpressure: result held for ten cycles, no issue until it is taken.
    res_ready = 0;
    base = delivered;
    push_pairs(3, "bp_pushes");
    g = 0;
    while (!res_valid && g < 100) begin tick(); g++; end
    chk("bp_res_valid_seen", 32'(res_valid), 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_res_valid_hold", 32'(res_valid), 1);
      chk("bp_res_z_hold", res_z, exp_q[0].z);
      chk("bp_res_tag_hold", 32'(res_tag), 32'(exp_q[0].tag));
      chk("bp_no_issue", 32'(mul_a_stb), 0);
    end
    res_ready = 1;
    tick();
    chk("bp_taken_valid", 32'(res_valid), 0);
    chk("bp_taken_a_stb", 32'(mul_a_stb), 0);
    tick();
    chk("bp_next_issue", 32'(mul_a_stb), 1);
    wait_delivered(base + 3, "bp_delivered");
    wait_idle("bp_idle");

    // Watchdog: product withheld for 40 cycles.
    z_delay = 40;
    base = delivered;
    push_pairs(1, "wd_push");
    g = 0;
    while (!mul_z_ack && g < 50) begin tick(); g++; end
    chk("wd_wait_p_entered", 32'(mul_z_ack), 1);
    for (int i = 0; i < 14; i++) tick();
    chk("wd_early", 32'(timeout_err), 0);
    for (int i = 0; i < 3; i++) tick();
    chk("wd_fired", 32'(timeout_err), 1);
    wait_delivered(base + 1, "wd_late_delivered");
    tick(); tick();
    chk("wd_sticky", 32'(timeout_err), 1);
    z_delay = 0;
    wait_idle("wd_idle");

    // Reset while stuck in SEND_B with three pairs queued.
    b_ack_en = 0;
    push_pairs(4, "rst_mid_pushes");
    chk("rst_mid_in_send_b", 32'(mul_b_stb), 1);
    chk("rst_mid_full_count", 32'(op_ready), 1);
    reset = 1;
    tick();
    chk("rst_mid_a_stb", 32'(mul_a_stb), 0);
    chk("rst_mid_b_stb", 32'(mul_b_stb), 0);
    chk("rst_mid_z_ack", 32'(mul_z_ack), 0);
    chk("rst_mid_res_valid", 32'(res_valid), 0);
    chk("rst_mid_op_ready", 32'(op_ready), 1);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_timeout_err", 32'(timeout_err), 0);
    reset = 0; b_ack_en = 1;
    base = delivered;
    push_pairs(1, "rst_mid_repush");
    wait_delivered(base + 1, "rst_mid_delivered");
    chk("rst_mid_tag0", last_tag, 0);
    wait_idle("rst_mid_idle");

    // Tag wrap: seventeen random normal pairs.
    do_reset();
    base = delivered;
    push_pairs(17, "wrap_pushes");
    wait_delivered(base + 17, "wrap_delivered");
    chk("wrap_last_tag", last_tag, 0);
    chk("wrap_scoreboard_empty", exp_q.size(), 0);
    wait_idle("wrap_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
